// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_ACK,
    S_DONE
  } loader_state_t;

  localparam logic [7:0]  ACK_OK_DEFAULT  = 8'hAA;
  localparam logic [7:0]  ACK_ERR_DEFAULT = 8'h55;
  localparam int unsigned BYTE_CNT_W      = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_done_o fires with the 4th byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]           low_q, low_d;

  always_comb begin
    cnt_d = cnt_q;
    low_d = low_q;
    if (clr_i) begin
      cnt_d = '0;
      low_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 1'b1;
      case (cnt_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      low_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

  // Top byte bypasses the register so the full word is usable in the 4th-byte cycle.
  assign word_o      = {byte_i, low_q};
  assign word_done_o = byte_valid_i && !clr_i && (cnt_q == '1);

endmodule

// File: rtl/program_loader.sv
// Program-load writer: length word, N data words to instruction memory, then an ack byte.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR = 32'd4,
  parameter int unsigned  MAX_WORDS = 23001,
  parameter logic [7:0]   ACK_OK    = ACK_OK_DEFAULT,
  parameter logic [7:0]   ACK_ERR   = ACK_ERR_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [31:0] pro_addr,
  output logic [31:0] pro_data,
  output logic        memwrite,
  output logic        loaded,
  output logic        load_error
);

  loader_state_t state_q, state_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [31:0]   word_idx_q, word_idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          memwrite_q, memwrite_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          loaded_q, loaded_d;
  logic          error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic          asm_valid, asm_clr, asm_done;
  logic [31:0]   asm_word;
  logic          go_ack;

  assign asm_valid = rx_valid && ((state_q == S_LEN) || (state_q == S_DATA));
  assign asm_clr   = !((state_q == S_LEN) || (state_q == S_DATA));

  word_assembler u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    memwrite_d  = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    loaded_d    = loaded_q;
    error_d     = error_q;
    go_ack      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    // Address advances the cycle after its strobe; overflowed words never strobe.
    if (memwrite_q) begin
      addr_d = addr_q + 32'd4;
    end

    case (state_q)
      S_LEN: begin
        if (asm_done) begin
          remaining_d = asm_word;
          if (asm_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            go_ack  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (rx_valid) begin
          xor_d = xor_q ^ rx_data;
        end
`endif
        if (asm_done) begin
          if (word_idx_q < MAX_WORDS) begin
            memwrite_d = 1'b1;
            data_d     = asm_word;
            word_idx_d = word_idx_q + 32'd1;
          end else begin
            error_d    = 1'b1;
          end
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            go_ack  = 1'b1;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data != xor_q) begin
            error_d = 1'b1;
          end
          go_ack = 1'b1;
        end
      end
`endif
      S_ACK: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          loaded_d   = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: ;
    endcase

    // Ack byte reflects an error raised in the same cycle as the final word/checksum.
    if (go_ack) begin
      state_d    = S_ACK;
      tx_valid_d = 1'b1;
      tx_data_d  = error_d ? ACK_ERR : ACK_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_LEN;
      remaining_q <= '0;
      word_idx_q  <= '0;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
      memwrite_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      memwrite_q  <= memwrite_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign pro_addr   = addr_q;
  assign pro_data   = data_q;
  assign memwrite   = memwrite_q;
  assign loaded     = loaded_q;
  assign load_error = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader; memory writes and ack bytes are checked by a monitor.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'd4;
  localparam int unsigned MAXW = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [31:0] pro_addr;
  logic [31:0] pro_data;
  logic        memwrite;
  logic        loaded;
  logic        load_error;

  program_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .ACK_OK    (8'hAA),
    .ACK_ERR   (8'h55)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .pro_addr   (pro_addr),
    .pro_data   (pro_data),
    .memwrite   (memwrite),
    .loaded     (loaded),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_wr_q[$];
  logic [7:0]  exp_ack_q[$];
  logic [31:0] load_words[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe and every ack handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rstn && memwrite) begin
      if (exp_wr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", pro_addr, pro_data);
      end else begin
        logic [63:0] e;
        e = exp_wr_q.pop_front();
        check("write_addr", pro_addr, e[63:32]);
        check("write_data", pro_data, e[31:0]);
      end
    end
    if (rstn && tx_valid && tx_ready) begin
      if (exp_ack_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got 0x%02h expected no ack", tx_data);
      end else begin
        check("ack_byte", {24'd0, tx_data}, {24'd0, exp_ack_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_pro_addr", pro_addr, BASE);
    check("rst_pro_data", pro_data, 32'd0);
    check("rst_memwrite", memwrite, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_loaded", loaded, 1'b0);
    check("rst_load_error", load_error, 1'b0);
  endtask

  // Reference: word i lands at BASE+4*i when i < MAXW; any dropped word (or bad checksum) is an error.
  task automatic do_load(input int unsigned stall, input bit bad_csum);
    int unsigned n;
    int unsigned waited;
    logic [7:0]  x;
    logic [7:0]  csum;
    logic [7:0]  exp_ack;
    logic        exp_err;
    logic [31:0] w;
    n = load_words.size();
    x = 8'h00;
    do_reset();
    exp_err = (n > MAXW);
    for (int i = 0; i < int'(n); i++) begin
      if (i < int'(MAXW)) exp_wr_q.push_back({BASE + 32'(4 * i), load_words[i]});
    end
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)));
    for (int i = 0; i < int'(n); i++) begin
      w = load_words[i];
      for (int k = 0; k < 4; k++) begin
        x = x ^ w[8*k +: 8];
        send_byte(w[8*k +: 8]);
      end
    end
    csum = bad_csum ? (x ^ 8'h01) : x;
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum);
    exp_err = exp_err | bad_csum;
`endif
    $display("load: %0d words, stall %0d, checksum byte %02h", n, stall, csum);
    exp_ack = exp_err ? 8'h55 : 8'hAA;

    waited = 0;
    while (!tx_valid && waited < 50) begin
      tick();
      waited++;
    end
    if (!tx_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got tx_valid 0 after 50 cycles expected 1");
    end else begin
      repeat (stall) begin
        check("stall_tx_valid", tx_valid, 1'b1);
        check("stall_tx_data", tx_data, exp_ack);
        check("stall_loaded", loaded, 1'b0);
        tick();
      end
      exp_ack_q.push_back(exp_ack);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    check("done_loaded", loaded, 1'b1);
    check("done_tx_valid", tx_valid, 1'b0);
    check("done_load_error", load_error, exp_err);
    check("pending_writes", exp_wr_q.size(), 0);
    check("pending_acks", exp_ack_q.size(), 0);

    // Traffic after completion must be ignored.
    repeat (3) send_byte(8'($urandom));
    tick();
    check("ignored_loaded", loaded, 1'b1);
    check("ignored_tx_valid", tx_valid, 1'b0);
    exp_wr_q.delete();
    exp_ack_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned nw;
    do_reset();

    load_words = '{32'h12345678, 32'hDEADBEEF};
    do_load(0, 1'b0);

    load_words.delete();
    do_load(0, 1'b0);

    load_words = '{32'hCAFEF00D};
    do_load(10, 1'b0);

    load_words = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_load(1, 1'b0);

    // Abandon a load two bytes into its first data word.
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hAB);
    send_byte(8'hCD);
    load_words = '{32'h00000001};
    do_load(0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    load_words = '{32'h01020304};
    do_load(0, 1'b0);
    do_load(2, 1'b1);
    load_words.delete();
    do_load(0, 1'b1);
`endif

    for (int t = 0; t < 10; t++) begin
      nw = $urandom_range(0, 4);
      load_words.delete();
      for (int i = 0; i < int'(nw); i++) load_words.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
      do_load($urandom_range(0, 3), 1'($urandom_range(0, 1)));
`else
      do_load($urandom_range(0, 3), 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
